// File: rtl/parity_rx_stream.sv
// ============================================================================
// Module      : parity_rx_stream
// Description : Even/odd parity checker on a valid/ready word stream with a
//               2-entry elastic output buffer, optional drop of bad words and
//               a saturating parity-error counter (built only when the macro
//               PARITY_ERR_CNT_EN is defined; otherwise err_cnt is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_rx_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  drop_err,
    output logic [DATA_WIDTH-1:0] out_byte,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic C_ODD = (ODD_PARITY != 0);

    // Each entry holds {err, payload}.
    logic [DATA_WIDTH:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic                r_in_ready;

    logic       w_accept;
    logic       w_bad;
    logic       w_store;
    logic       w_pop;
    logic [1:0] w_count_next;

    assign w_accept = in_valid & r_in_ready;
    assign w_bad    = (^in_data) != C_ODD;
    assign w_store  = w_accept & ~(w_bad & drop_err);
    assign w_pop    = (r_count != 2'd0) & out_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_store && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_store && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= {w_bad, in_data[DATA_WIDTH-1:0]};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_next;
            // Registered ready tracks next occupancy so it never looks at out_ready combinationally.
            r_in_ready <= (w_count_next != 2'd2);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_byte  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign out_err   = r_mem[r_rd_ptr][DATA_WIDTH];

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_bad && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign err_cnt          = '0;
`endif

endmodule

`default_nettype wire
